// File: rtl/palu_arbiter.sv
// palu_arbiter: round-robin share of one eightbit_palu between two requesters.
// Optional PALU_ARB_OVFCNT_EN adds a saturating overflow-response counter.
module palu_arbiter #(
    parameter int DW = 8,
    parameter int SW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [DW-1:0] req_a0,
    input  logic [DW-1:0] req_b0,
    input  logic [SW-1:0] req_sel0,
    input  logic [DW-1:0] req_a1,
    input  logic [DW-1:0] req_b1,
    input  logic [SW-1:0] req_sel1,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [SW-1:0] alu_sel,
    input  logic [DW-1:0] alu_f,
    input  logic          alu_ovf,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_f,
    output logic          rsp_ovf,
    output logic          busy
`ifdef PALU_ARB_OVFCNT_EN
    ,
    output logic [7:0]    ovf_count
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0] state;
    logic       last_grant;
    logic       gnt;
    logic       take;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        gnt = req_valid[1];
        if (&req_valid) gnt = ~last_grant;
    end

    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && |req_valid) req_ready[gnt] = 1'b1;
    end

    assign take = |(req_valid & req_ready);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_f      <= '0;
            rsp_ovf    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        alu_a      <= gnt ? req_a1 : req_a0;
                        alu_b      <= gnt ? req_b1 : req_b0;
                        alu_sel    <= gnt ? req_sel1 : req_sel0;
                        rsp_id     <= gnt;
                        last_grant <= gnt;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_f     <= alu_f;
                    rsp_ovf   <= alu_ovf;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PALU_ARB_OVFCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= 8'd0;
        end else if (state == RESP && rsp_ready && rsp_ovf
                     && ovf_count != 8'hFF) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_palu_arbiter.sv
// tb_palu_arbiter: randomized and directed checks of palu_arbiter
// against a transaction-level reference model with a palu stub.
module tb_palu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [7:0] ra [2];
    logic [7:0] rb [2];
    logic [1:0] rs [2];
    logic [7:0] alu_a, alu_b, alu_f, rsp_f;
    logic [1:0] alu_sel;
    logic       alu_ovf, rsp_valid, rsp_ready, rsp_id, rsp_ovf, busy;
`ifdef PALU_ARB_OVFCNT_EN
    logic [7:0] ovf_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign alu_f   = alu_a ^ alu_b;
    assign alu_ovf = alu_sel[0];

    palu_arbiter #(.DW(8), .SW(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(ra[0]), .req_b0(rb[0]), .req_sel0(rs[0]),
        .req_a1(ra[1]), .req_b1(rb[1]), .req_sel1(rs[1]),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_f(alu_f), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_f(rsp_f), .rsp_ovf(rsp_ovf),
        .busy(busy)
`ifdef PALU_ARB_OVFCNT_EN
        , .ovf_count(ovf_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: an operation owns the ALU from its accept edge until
    // its response is taken; the result shows two edges after accept.
    bit       m_free;
    int       m_age;
    int       m_last;
    int       m_acc;
    bit [7:0] m_a, m_b, m_rf;
    bit [1:0] m_s;
    bit       m_id, m_ro;
    int       m_cnt;
    int       log_id [$];
    int       log_f  [$];

    function automatic void m_reset();
        m_free = 1; m_age = 0; m_last = 1; m_acc = -1;
        m_a = 0; m_b = 0; m_s = 0; m_rf = 0; m_id = 0; m_ro = 0;
        m_cnt = 0;
    endfunction

    function automatic int pred();
        if (rst || !m_free) return -1;
        if (req_valid == 2'b11) return (m_last == 0) ? 1 : 0;
        if (req_valid[0]) return 0;
        if (req_valid[1]) return 1;
        return -1;
    endfunction

    task automatic compare();
        logic [1:0] er;
        int g;
        bit ev;
        g  = pred();
        er = 2'b00;
        if (g >= 0) er[g] = 1'b1;
        ev = !m_free && m_age >= 2;
        check("req_ready", 32'(req_ready), 32'(er));
        check("busy", 32'(busy), 32'(!m_free));
        check("rsp_valid", 32'(rsp_valid), 32'(ev));
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_f", 32'(rsp_f), 32'(m_rf));
        check("rsp_ovf", 32'(rsp_ovf), 32'(m_ro));
        check("alu_a", 32'(alu_a), 32'(m_a));
        check("alu_b", 32'(alu_b), 32'(m_b));
        check("alu_sel", 32'(alu_sel), 32'(m_s));
`ifdef PALU_ARB_OVFCNT_EN
        check("ovf_count", 32'(ovf_count), 32'(m_cnt));
`endif
        if (rsp_valid && rsp_ready) begin
            log_id.push_back(int'(rsp_id));
            log_f.push_back(int'(rsp_f));
        end
    endtask

    function automatic void m_edge();
        int g;
        if (rst) begin
            m_reset();
            return;
        end
        g = pred();
        m_acc = -1;
        if (m_free) begin
            if (g >= 0) begin
                m_free = 0; m_age = 1; m_last = g; m_acc = g;
                m_a = ra[g]; m_b = rb[g]; m_s = rs[g]; m_id = g[0];
            end
        end else if (m_age >= 2) begin
            if (rsp_ready) begin
                m_free = 1;
                if (m_ro && m_cnt < 255) m_cnt++;
            end
        end else begin
            m_age = 2;
            m_rf = m_a ^ m_b;
            m_ro = m_s[0];
        end
    endfunction

    task automatic step();
        #1;
        compare();
        m_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        m_reset();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic set_req(input int i, input logic [7:0] a,
                           input logic [7:0] b, input logic [1:0] s);
        ra[i] = a; rb[i] = b; rs[i] = s;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        #1;
        while (!rsp_valid && n < 10) begin
            step();
            n++;
            #1;
        end
        check(tag, 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        int bcnt;
        set_req(0, 8'h00, 8'h00, 2'b00);
        set_req(1, 8'h00, 8'h00, 2'b00);
        rsp_ready = 1'b1;
        m_reset();
        @(negedge clk);
        do_reset();

        // single request
        req_valid = 2'b01;
        set_req(0, 8'h0F, 8'hF0, 2'b01);
        #1 check("single_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        #1 check("single_issue_nv", 32'(rsp_valid), 32'd0);
        step();
        #1;
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_f", 32'(rsp_f), 32'hFF);
        check("single_ovf", 32'(rsp_ovf), 32'd1);
        check("single_id", 32'(rsp_id), 32'd0);
        bcnt = 2;
        step();
        for (int k = 0; k < 3; k++) begin
            #1 if (busy) bcnt++;
            step();
        end
        check("single_busy_cycles", 32'(bcnt), 32'd2);

        // tie and alternation
        do_reset();
        set_req(0, 8'h11, 8'h00, 2'b00);
        set_req(1, 8'h22, 8'h00, 2'b00);
        req_valid = 2'b11;
        log_id.delete(); log_f.delete();
        for (int k = 0; k < 20 && log_id.size() < 4; k++) step();
        check("tie_count", 32'(log_id.size() >= 4), 32'd1);
        if (log_id.size() >= 4) begin
            check("tie_id0", 32'(log_id[0]), 32'd0);
            check("tie_f0", 32'(log_f[0]), 32'h11);
            check("tie_id1", 32'(log_id[1]), 32'd1);
            check("tie_f1", 32'(log_f[1]), 32'h22);
            check("tie_id2", 32'(log_id[2]), 32'd0);
            check("tie_id3", 32'(log_id[3]), 32'd1);
        end

        // backpressure
        do_reset();
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        wait_rsp("bp_reach_resp");
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_ready", 32'(req_ready), 32'h0);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_f", 32'(rsp_f), 32'h11);
            check("bp_id", 32'(rsp_id), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        #1 check("bp_next_grant", 32'(req_ready), 32'h2);
        step();

        // dropped request
        do_reset();
        set_req(0, 8'h33, 8'h0C, 2'b00);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        step();
        req_valid = 2'b00;
        step();
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        step();
        rsp_ready = 1'b1;
        log_id.delete(); log_f.delete();
        for (int k = 0; k < 6; k++) step();
        check("drop_rsp_count", 32'(log_id.size()), 32'd1);
        if (log_id.size() > 0) begin
            check("drop_rsp_id", 32'(log_id[0]), 32'd0);
            check("drop_rsp_f", 32'(log_f[0]), 32'h3F);
        end

        // reset during ISSUE
        do_reset();
        set_req(0, 8'h5A, 8'h00, 2'b01);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_alu_a", 32'(alu_a), 32'h00);
        check("rst_mid_busy", 32'(busy), 32'd0);
        m_reset();
        step();
        rst = 1'b0;
        log_id.delete(); log_f.delete();
        for (int k = 0; k < 4; k++) step();
        check("rst_mid_no_rsp", 32'(log_id.size()), 32'd0);
        req_valid = 2'b11;
        #1 check("rst_mid_tie", 32'(req_ready), 32'h1);
        step();

`ifdef PALU_ARB_OVFCNT_EN
        do_reset();
        set_req(0, 8'h01, 8'h02, 2'b01);
        req_valid = 2'b01;
        for (int k = 0; k < 900; k++) step();
        check("ovfcnt_sat", 32'(ovf_count), 32'd255);
        do_reset();
        set_req(0, 8'h01, 8'h02, 2'b00);
        req_valid = 2'b01;
        for (int k = 0; k < 900; k++) step();
        check("ovfcnt_zero", 32'(ovf_count), 32'd0);
`endif

        // randomized traffic
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && m_acc != i) begin
                    if ($urandom % 8 == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = 1'($urandom % 2);
                    set_req(i, 8'($urandom), 8'($urandom), 2'($urandom));
                end
            end
            rsp_ready = ($urandom % 4) != 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
